// File: rtl/cpu_pkg.sv
// Shared types and default widths for the Falcon operand-fetch slice.
// Bypass selection encoding used by the per-source operand muxes.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_W  = 5;

  typedef logic [CPU_REG_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    SEL_REG,
    SEL_P3,
    SEL_P4,
    SEL_LIT,
    SEL_ZERO
  } byp_sel_t;

endpackage

// File: rtl/cpu_regfile_mp.sv
// Multi-read-port register file, one stall-gated write port.
// Reads are combinational; r0 always reads zero.
module cpu_regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int REG_W   = CPU_REG_W,
  parameter int NUM_SRC = 2
) (
  input  logic                      clock,
  input  logic                      stall,
  input  logic                      wr_en,
  input  logic [REG_W-1:0]          wr_idx,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [NUM_SRC*REG_W-1:0]  rd_idx,
  output logic [NUM_SRC*DATA_W-1:0] rd_data
);

  localparam int NREG = 1 << REG_W;

  logic [DATA_W-1:0] mem [NREG];

  // writeback; frozen under stall, r0 never written
  always_ff @(posedge clock) begin
    if (!stall && wr_en && wr_idx != '0)
      mem[wr_idx] <= wr_data;
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_rd
    logic [REG_W-1:0] idx;
    assign idx = rd_idx[k*REG_W +: REG_W];
    assign rd_data[k*DATA_W +: DATA_W] =
      (idx == '0) ? '0 : mem[idx];
  end

endmodule

// File: rtl/cpu_operand_fetch.sv
// Falcon p2->p3 operand fetch: regfile read, bypass select,
// load-use hazard detection and p3 pipeline register.
module cpu_operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int REG_W   = CPU_REG_W,
  parameter int NUM_SRC = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      stall,
  input  logic                      p2_valid,
  input  logic [NUM_SRC*REG_W-1:0]  p2_reg_src,
  input  logic                      p2_literal_b,
  input  logic [DATA_W-1:0]         p2_literal_value,
  input  logic [REG_W-1:0]          p2_reg_d,
  input  logic                      p2_write_en,
  input  logic                      p2_is_load,
  input  logic [DATA_W-1:0]         p3_alu_out,
  input  logic [DATA_W-1:0]         p4_data_out,
  input  logic [REG_W-1:0]          p4_reg_d,
  input  logic                      p4_write_en,
  output logic [NUM_SRC*DATA_W-1:0] p3_data,
  output logic [DATA_W-1:0]         p3_literal,
  output logic                      p3_valid,
  output logic [REG_W-1:0]          p3_reg_d,
  output logic                      p3_write_en,
  output logic                      p3_is_load,
  output logic                      hazard_stall
);

  logic [NUM_SRC*DATA_W-1:0] rf_rd;
  logic [NUM_SRC*DATA_W-1:0] opnd;
  logic [NUM_SRC-1:0]        haz;
  logic                      p3_ld_live;

  cpu_regfile_mp #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .NUM_SRC (NUM_SRC)
  ) u_rf (
    .clock   (clock),
    .stall   (stall),
    .wr_en   (p4_write_en),
    .wr_idx  (p4_reg_d),
    .wr_data (p4_data_out),
    .rd_idx  (p2_reg_src),
    .rd_data (rf_rd)
  );

  assign p3_ld_live = p3_valid && p3_is_load &&
                      p3_write_en && (p3_reg_d != '0);

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_W-1:0]  src;
    logic              lit_k;
    logic              p3_hit;
    logic              p4_hit;
    byp_sel_t          sel;
    logic [DATA_W-1:0] val;

    assign src    = p2_reg_src[k*REG_W +: REG_W];
    assign lit_k  = (k == 1) && p2_literal_b;
    assign p3_hit = p3_valid && p3_write_en &&
                    (p3_reg_d == src);
    assign p4_hit = p4_write_en && (p4_reg_d == src);

    // priority pick: literal, r0, newest bypass, older, regfile
    always_comb begin
      if (lit_k)             sel = SEL_LIT;
      else if (src == '0)    sel = SEL_ZERO;
      else if (p3_hit)       sel = SEL_P3;
      else if (p4_hit)       sel = SEL_P4;
      else                   sel = SEL_REG;
    end

    // operand mux driven by the decoded select
    always_comb begin
      unique case (sel)
        SEL_LIT:  val = p2_literal_value;
        SEL_ZERO: val = '0;
        SEL_P3:   val = p3_alu_out;
        SEL_P4:   val = p4_data_out;
        default:  val = rf_rd[k*DATA_W +: DATA_W];
      endcase
    end

    assign opnd[k*DATA_W +: DATA_W] = val;
    assign haz[k] = !lit_k && p3_ld_live &&
                    (src == p3_reg_d);
  end

  assign hazard_stall = p2_valid && (|haz);

  // p3 register: hold on stall, bubble on load-use
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p3_data     <= '0;
      p3_literal  <= '0;
      p3_reg_d    <= '0;
      p3_valid    <= 1'b0;
      p3_write_en <= 1'b0;
      p3_is_load  <= 1'b0;
    end else if (!stall) begin
      if (hazard_stall) begin
        p3_valid    <= 1'b0;
        p3_write_en <= 1'b0;
        p3_is_load  <= 1'b0;
      end else begin
        p3_data     <= opnd;
        p3_literal  <= p2_literal_value;
        p3_reg_d    <= p2_reg_d;
        p3_valid    <= p2_valid;
        p3_write_en <= p2_write_en && p2_valid;
        p3_is_load  <= p2_is_load;
      end
    end
  end

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed bench for cpu_operand_fetch (NUM_SRC=3).
// Expected p3 contents are queued at drive time, popped after the edge.
module tb_cpu_operand_fetch;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int NS = 3;

  logic           clock;
  logic           resetn;
  logic           stall;
  logic           p2_valid;
  logic [NS*RW-1:0] p2_reg_src;
  logic           p2_literal_b;
  logic [DW-1:0]  p2_literal_value;
  logic [RW-1:0]  p2_reg_d;
  logic           p2_write_en;
  logic           p2_is_load;
  logic [DW-1:0]  p3_alu_out;
  logic [DW-1:0]  p4_data_out;
  logic [RW-1:0]  p4_reg_d;
  logic           p4_write_en;
  logic [NS*DW-1:0] p3_data;
  logic [DW-1:0]  p3_literal;
  logic           p3_valid;
  logic [RW-1:0]  p3_reg_d;
  logic           p3_write_en;
  logic           p3_is_load;
  logic           hazard_stall;

  cpu_operand_fetch #(
    .DATA_W  (DW),
    .REG_W   (RW),
    .NUM_SRC (NS)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .stall            (stall),
    .p2_valid         (p2_valid),
    .p2_reg_src       (p2_reg_src),
    .p2_literal_b     (p2_literal_b),
    .p2_literal_value (p2_literal_value),
    .p2_reg_d         (p2_reg_d),
    .p2_write_en      (p2_write_en),
    .p2_is_load       (p2_is_load),
    .p3_alu_out       (p3_alu_out),
    .p4_data_out      (p4_data_out),
    .p4_reg_d         (p4_reg_d),
    .p4_write_en      (p4_write_en),
    .p3_data          (p3_data),
    .p3_literal       (p3_literal),
    .p3_valid         (p3_valid),
    .p3_reg_d         (p3_reg_d),
    .p3_write_en      (p3_write_en),
    .p3_is_load       (p3_is_load),
    .hazard_stall     (hazard_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        full;
    logic        v;
    logic        we;
    logic        ld;
    logic [4:0]  rd;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] lit;
  } exp_t;

  exp_t q[$];
  int passes = 0;
  int fails  = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic p2drive(input logic v,
                         input logic [4:0] s0,
                         input logic [4:0] s1,
                         input logic [4:0] s2,
                         input logic lb,
                         input logic [31:0] lit,
                         input logic [4:0] rd,
                         input logic we,
                         input logic ld);
    p2_valid         = v;
    p2_reg_src       = {s2, s1, s0};
    p2_literal_b     = lb;
    p2_literal_value = lit;
    p2_reg_d         = rd;
    p2_write_en      = we;
    p2_is_load       = ld;
  endtask

  task automatic p4drive(input logic we,
                         input logic [4:0] rd,
                         input logic [31:0] d);
    p4_write_en = we;
    p4_reg_d    = rd;
    p4_data_out = d;
  endtask

  task automatic push_full(input logic v, input logic we,
                           input logic ld, input logic [4:0] rd,
                           input logic [31:0] d0,
                           input logic [31:0] d1,
                           input logic [31:0] d2,
                           input logic [31:0] lit);
    exp_t e;
    e.full = 1'b1; e.v = v; e.we = we; e.ld = ld; e.rd = rd;
    e.d0 = d0; e.d1 = d1; e.d2 = d2; e.lit = lit;
    q.push_back(e);
  endtask

  task automatic push_flags(input logic v, input logic we,
                            input logic ld);
    exp_t e;
    e.full = 1'b0; e.v = v; e.we = we; e.ld = ld; e.rd = '0;
    e.d0 = '0; e.d1 = '0; e.d2 = '0; e.lit = '0;
    q.push_back(e);
  endtask

  task automatic chk_p3(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      if (e.full) begin
        chk({tag, "_ctl"},
            {p3_valid, p3_write_en, p3_is_load, p3_reg_d},
            {e.v, e.we, e.ld, e.rd});
        chk({tag, "_data"}, p3_data, {e.d2, e.d1, e.d0});
        chk({tag, "_lit"}, p3_literal, e.lit);
      end else begin
        chk({tag, "_flags"},
            {p3_valid, p3_write_en, p3_is_load},
            {e.v, e.we, e.ld});
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    stall  = 1'b0;
    p3_alu_out = '0;
    p2drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    p4drive(0, 0, 0);

    repeat (4) begin
      stall = 1'($urandom);
      p2drive(1'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 1'($urandom), $urandom,
              5'($urandom), 1'($urandom), 1'($urandom));
      p4drive(1'($urandom), 5'($urandom), $urandom);
      p3_alu_out = $urandom;
      @(posedge clock);
    end
    #1;
    chk("rst_ctl",
        {p3_valid, p3_write_en, p3_is_load, p3_reg_d, p3_literal},
        '0);
    chk("rst_data", p3_data, '0);
    chk("rst_haz", hazard_stall, 1'b0);

    stall = 1'b0;
    p3_alu_out = '0;
    p2drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    p4drive(0, 0, 0);
    #3 resetn = 1'b1;
    cyc();

    p4drive(1, 5, 32'h1234);
    cyc();
    p4drive(1, 12, 32'h111);
    cyc();
    p4drive(0, 0, 0);
    p2drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
    push_full(1, 0, 0, 0, 32'h1234, 0, 0, 0);
    cyc();
    chk_p3("r5_read");

    p2drive(1, 0, 0, 0, 0, 0, 3, 1, 0);
    push_full(1, 1, 0, 3, 0, 0, 0, 0);
    cyc();
    chk_p3("alu_r3");
    p2drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    p3_alu_out = 32'hAA;
    p4drive(1, 3, 32'hBB);
    #1 chk("fwd_haz", hazard_stall, 1'b0);
    push_full(1, 0, 0, 0, 32'hAA, 0, 0, 0);
    cyc();
    chk_p3("fwd_p3_wins");
    p3_alu_out = '0;
    p4drive(0, 0, 0);

    p2drive(1, 0, 0, 0, 0, 0, 7, 1, 1);
    push_full(1, 1, 1, 7, 0, 0, 0, 0);
    cyc();
    chk_p3("ld_r7");
    p2drive(1, 7, 0, 0, 0, 0, 9, 1, 0);
    #1 chk("lu_haz", hazard_stall, 1'b1);
    push_flags(0, 0, 0);
    cyc();
    chk_p3("lu_bubble");
    p4drive(1, 7, 32'h55);
    #1 chk("lu_haz_clr", hazard_stall, 1'b0);
    push_full(1, 1, 0, 9, 32'h55, 0, 0, 0);
    cyc();
    chk_p3("lu_p4_fwd");
    p4drive(0, 0, 0);

    p2drive(1, 0, 0, 0, 0, 0, 7, 1, 1);
    push_full(1, 1, 1, 7, 0, 0, 0, 0);
    cyc();
    chk_p3("ld2_r7");
    p2drive(1, 0, 7, 0, 1, 32'hDEADBEEF, 0, 1, 0);
    p4drive(1, 0, 32'hFFFF);
    #1 chk("lit_no_haz", hazard_stall, 1'b0);
    push_full(1, 1, 0, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    cyc();
    chk_p3("lit_r0");
    p2drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    p3_alu_out = 32'h77;
    push_full(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_p3("r0_no_byp");
    p3_alu_out = '0;
    p4drive(0, 0, 0);

    p2drive(1, 0, 0, 0, 0, 0, 10, 1, 0);
    push_full(1, 1, 0, 10, 0, 0, 0, 0);
    cyc();
    chk_p3("i_r10");
    stall = 1'b1;
    p2drive(1, 10, 12, 0, 0, 0, 11, 1, 0);
    p4drive(1, 12, 32'h999);
    p3_alu_out = 32'h10;
    for (int i = 0; i < 3; i++) begin
      push_full(1, 1, 0, 10, 0, 0, 0, 0);
      cyc();
      chk_p3("stall_hold");
    end
    stall = 1'b0;
    p4drive(0, 0, 0);
    push_full(1, 1, 0, 11, 32'h10, 32'h111, 0, 0);
    cyc();
    chk_p3("stall_resume");
    p3_alu_out = '0;
    p2drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_full(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk_p3("no_dup");

    p2drive(1, 0, 0, 0, 0, 0, 20, 1, 0);
    push_full(1, 1, 0, 20, 0, 0, 0, 0);
    cyc();
    chk_p3("i_r20");
    p2drive(1, 5, 20, 21, 0, 0, 0, 0, 0);
    p3_alu_out = 32'h2020;
    p4drive(1, 21, 32'h2121);
    push_full(1, 0, 0, 0, 32'h1234, 32'h2020, 32'h2121, 0);
    cyc();
    chk_p3("three_src");
    p3_alu_out = '0;
    p4drive(0, 0, 0);

    p2drive(1, 0, 0, 0, 0, 0, 22, 1, 1);
    push_full(1, 1, 1, 22, 0, 0, 0, 0);
    cyc();
    chk_p3("ld_r22");
    stall = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_ctl",
        {p3_valid, p3_write_en, p3_is_load, p3_reg_d, p3_literal},
        '0);
    chk("rst_mid_data", p3_data, '0);
    chk("sb_empty", 96'(q.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
